// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - I2S transmit serializer; sclk from clk_div is sampled as data in the pclk domain.
module i2s_tx_serializer #(
    parameter int DW   = 32,
    parameter int SYNC = 2
) (
    input  logic          pclk,
    input  logic          rst_,
    input  logic          sclk_in,
    input  logic          en,
    input  logic          stereo,
    input  logic          frame32,
    input  logic [DW-1:0] data_l,
    input  logic [DW-1:0] data_r,
    input  logic          valid,
    output logic          ready,
    output logic          ws,
    output logic          sd,
    output logic          underrun,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, START, RUN} state_t;

    state_t          state;
    logic [SYNC-1:0] sclk_sync;
    logic            sclk_hist;
    logic            fall_tick;

    logic [31:0]     data_l32;
    logic [31:0]     data_r32;

    logic [31:0]     buf_l;
    logic [31:0]     buf_r;
    logic            buf_stereo;
    logic            buf_f32;
    logic            buf_full;

    logic [31:0]     cur_l;
    logic [31:0]     cur_r;
    logic            cur_stereo;
    logic            cur_f32;
    logic            slot;
    logic [4:0]      k;

    logic [4:0]      last_k;
    logic            at_last;
    logic            boundary;
    logic            consume;
    logic [31:0]     slot_word;
    logic [4:0]      bit_idx;

    always_ff @(posedge pclk or negedge rst_) begin
        if (!rst_) begin
            sclk_sync <= '0;
            sclk_hist <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC-2:0], sclk_in};
            sclk_hist <= sclk_sync[SYNC-1];
        end
    end

    assign fall_tick = sclk_hist & ~sclk_sync[SYNC-1];

    // Words are held at 32 bits internally; 16-bit slots only ever index [15:0].
    assign data_l32 = 32'(data_l);
    assign data_r32 = 32'(data_r);

    assign last_k    = cur_f32 ? 5'd31 : 5'd15;
    assign at_last   = (k == last_k);
    assign boundary  = (state == RUN) && fall_tick && slot && at_last;
    assign consume   = buf_full && ((state == START && fall_tick) || (boundary && en));
    assign slot_word = (slot && cur_stereo) ? cur_r : cur_l;
    assign bit_idx   = last_k - k;

    assign ready = ~buf_full;
    assign busy  = (state != IDLE);

    // Consume wins over a simultaneous load; ready is already low then since the buffer is full.
    always_ff @(posedge pclk or negedge rst_) begin
        if (!rst_) begin
            buf_l      <= '0;
            buf_r      <= '0;
            buf_stereo <= 1'b0;
            buf_f32    <= 1'b0;
            buf_full   <= 1'b0;
        end else if (consume) begin
            buf_full <= 1'b0;
        end else if (valid && !buf_full) begin
            buf_l      <= data_l32;
            buf_r      <= data_r32;
            buf_stereo <= stereo;
            buf_f32    <= frame32;
            buf_full   <= 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge rst_) begin
        if (!rst_) begin
            state      <= IDLE;
            ws         <= 1'b1;
            sd         <= 1'b0;
            underrun   <= 1'b0;
            cur_l      <= '0;
            cur_r      <= '0;
            cur_stereo <= 1'b0;
            cur_f32    <= 1'b0;
            slot       <= 1'b0;
            k          <= '0;
        end else begin
            underrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall_tick) begin
                        ws <= 1'b1;
                        sd <= 1'b0;
                    end
                    if (en && buf_full) begin
                        state <= START;
                    end
                end
                START: begin
                    if (fall_tick) begin
                        cur_l      <= buf_l;
                        cur_r      <= buf_r;
                        cur_stereo <= buf_stereo;
                        cur_f32    <= buf_f32;
                        ws         <= 1'b0;
                        sd         <= 1'b0;
                        slot       <= 1'b0;
                        k          <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (fall_tick) begin
                        sd <= slot_word[bit_idx];
                        // ws flips alongside the LSB so the next MSB lags it by one sclk.
                        ws <= at_last ? ~slot : slot;
                        if (at_last) begin
                            k    <= '0;
                            slot <= ~slot;
                            if (slot) begin
                                if (en && buf_full) begin
                                    cur_l      <= buf_l;
                                    cur_r      <= buf_r;
                                    cur_stereo <= buf_stereo;
                                    cur_f32    <= buf_f32;
                                end else if (en) begin
                                    underrun <= 1'b1;
                                    cur_l    <= '0;
                                    cur_r    <= '0;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        end else begin
                            k <= k + 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb/tb_i2s_tx_serializer.sv - scoreboard bench for i2s_tx_serializer, sampling ws/sd on sclk rising edges.
module tb_i2s_tx_serializer;
    localparam int DW = 32;

    logic          pclk = 1'b0;
    logic          rst_;
    logic          sclk_in = 1'b1;
    logic          en;
    logic          stereo;
    logic          frame32;
    logic [DW-1:0] data_l;
    logic [DW-1:0] data_r;
    logic          valid;
    logic          ready;
    logic          ws;
    logic          sd;
    logic          underrun;
    logic          busy;

    int            total = 0;
    int            bad = 0;
    int            ur_total = 0;
    int            ur_seen = 0;
    int            bit_no = 0;
    logic          busy_at_fall = 1'b0;
    logic [2:0]    exp_q[$];

    i2s_tx_serializer #(.DW(DW), .SYNC(2)) dut (
        .pclk     (pclk),
        .rst_     (rst_),
        .sclk_in  (sclk_in),
        .en       (en),
        .stereo   (stereo),
        .frame32  (frame32),
        .data_l   (data_l),
        .data_r   (data_r),
        .valid    (valid),
        .ready    (ready),
        .ws       (ws),
        .sd       (sd),
        .underrun (underrun),
        .busy     (busy)
    );

    always #5 pclk = ~pclk;
    // sclk period of 8 pclk, edges aligned to pclk falling edges
    always #40 sclk_in = ~sclk_in;

    always @(negedge pclk) begin
        if (underrun === 1'b1) ur_total++;
    end

    always @(negedge sclk_in) busy_at_fall = busy;

    // I2S receiver view: every rising sclk after a busy falling edge carries one DUT bit.
    always @(posedge sclk_in) begin
        int         d;
        logic [2:0] e;
        d       = ur_total - ur_seen;
        ur_seen = ur_total;
        if (busy_at_fall) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_bit got ws=%b sd=%b ur=%0d exp none", ws, sd, d);
            end else begin
                e = exp_q.pop_front();
                if (ws !== e[2] || sd !== e[1] || d != int'(e[0])) begin
                    bad++;
                    $display("FAIL stream_bit[%0d] got ws=%b sd=%b ur=%0d exp ws=%b sd=%b ur=%0d",
                             bit_no, ws, sd, d, e[2], e[1], e[0]);
                end
            end
            bit_no++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic wait_rises(input int n);
        repeat (n) @(posedge sclk_in);
        #12;
    endtask

    task automatic push_start();
        exp_q.push_back(3'b000);
    endtask

    task automatic push_frame(input int w, input logic [31:0] l, input logic [31:0] r,
                              input logic ur_last);
        for (int s = 0; s < 2; s++) begin
            for (int kk = 0; kk < w; kk++) begin
                logic [31:0] word;
                logic        wsb;
                logic        sdb;
                logic        urb;
                word = (s == 1) ? r : l;
                sdb  = word[w-1-kk];
                wsb  = (kk == w - 1) ? (s == 0) : (s == 1);
                urb  = (s == 1 && kk == w - 1) ? ur_last : 1'b0;
                exp_q.push_back({wsb, sdb, urb});
            end
        end
    endtask

    task automatic offer(input logic [31:0] l, input logic [31:0] r);
        int n;
        data_l = l;
        data_r = r;
        valid  = 1'b1;
        n      = 0;
        while (ready !== 1'b1 && n < 200) begin
            #10;
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL offer_timeout got ready=%b exp 1", ready);
        end else begin
            #10;
        end
        valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ws"}, 32'(ws), 32'd1);
        check({tag, "_sd"}, 32'(sd), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_    = 1'b0;
        en      = 1'b0;
        stereo  = 1'b1;
        frame32 = 1'b0;
        data_l  = '0;
        data_r  = '0;
        valid   = 1'b0;
        #22;
        check_idle("reset");
        check("reset_underrun", 32'(underrun), 32'd0);
        #10;
        rst_ = 1'b1;

        // stereo 16-bit frame, then two all-zero frames; en dropped during the second
        en = 1'b1;
        wait_rises(1);
        push_start();
        push_frame(16, 32'h0000_A5C3, 32'h0000_0F0F, 1'b1);
        push_frame(16, 32'h0, 32'h0, 1'b1);
        push_frame(16, 32'h0, 32'h0, 1'b0);
        offer(32'h0000_A5C3, 32'h0000_0F0F);
        wait_rises(70);
        en = 1'b0;
        wait_rises(30);
        check_idle("p1_end");

        // back-to-back 16-bit then 32-bit frame
        en = 1'b1;
        wait_rises(1);
        push_start();
        push_frame(16, 32'h0000_A5C3, 32'h0000_0F0F, 1'b0);
        push_frame(32, 32'h8000_0001, 32'hFFFF_FFFF, 1'b0);
        offer(32'h0000_A5C3, 32'h0000_0F0F);
        frame32 = 1'b1;
        offer(32'h8000_0001, 32'hFFFF_FFFF);
        check("p2_ready_after_load", 32'(ready), 32'd0);
        wait_rises(33);
        check("p2_ready_after_boundary", 32'(ready), 32'd1);
        en = 1'b0;
        wait_rises(66);
        check_idle("p2_end");

        // mono 16-bit; stereo flipped mid-frame and en dropped at slot 0 k=5
        stereo  = 1'b0;
        frame32 = 1'b0;
        en      = 1'b1;
        wait_rises(1);
        push_start();
        push_frame(16, 32'h0000_1234, 32'h0000_1234, 1'b0);
        offer(32'h0000_1234, 32'h0000_FFFF);
        stereo = 1'b1;
        wait_rises(6);
        en = 1'b0;
        wait_rises(36);
        check_idle("p3_end");

        // reset mid-frame with a second frame buffered
        en = 1'b1;
        wait_rises(1);
        push_start();
        push_frame(16, 32'h0000_C0DE, 32'h0000_BEEF, 1'b0);
        offer(32'h0000_C0DE, 32'h0000_BEEF);
        offer(32'h0000_5555, 32'h0000_AAAA);
        check("p4_buffer_full", 32'(ready), 32'd0);
        wait_rises(10);
        rst_ = 1'b0;
        #1;
        check_idle("p4_reset");
        check("p4_reset_underrun", 32'(underrun), 32'd0);
        exp_q.delete();
        #20;
        rst_ = 1'b1;
        wait_rises(40);
        check_idle("p4_after");
        en = 1'b0;

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
